peak_picker: RTL and testbench

PEAK_PICKER -- requirements
Module: peak_picker

---
 rtl/peak_picker.sv | 172 +++++++++++++++++
 tb/tb_peak_picker.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_picker.sv
// peak_picker
//   Selects the strongest peak reported by NUM_BRANCHES parallel detector
//   branches. The first peak opens a collection window of HOLD_LEN valid
//   samples. Within that window a later peak replaces the stored one only
//   when its score is strictly larger. At the end of the window the winner
//   (sample index, branch number, score) is presented on an AXI-stream
//   style output and held until the downstream side accepts it.
//
// Optional feature (compile-time macro): PEAK_PICKER_DROP_CNT_EN
//   Adds dropped_cnt_o. This is a saturating 16-bit count of valid samples
//   that carried a peak and were discarded while a result waited for
//   acceptance.
//
// Ports
//   clk_i              clock, rising edge
//   reset_i            asynchronous active-high reset
//   s_axis_in_tvalid   sample strobe shared by all branches
//   peak_detected_i    per-branch peak flag (bit b = branch b)
//   score_i            per-branch unsigned score, branch b at [b*SCORE_DW +: SCORE_DW]
//   m_axis_out_tvalid  result valid (registered)
//   m_axis_out_tready  downstream accept
//   m_axis_out_tdata   sample index of the winning peak
//   m_axis_out_tuser   winning branch number
//   score_o            winning score
//   dropped_cnt_o      dropped-peak count (only with PEAK_PICKER_DROP_CNT_EN)
module peak_picker #(
  parameter int SCORE_DW     = 32,
  parameter int NUM_BRANCHES = 3,
  parameter int HOLD_LEN     = 16,
  parameter int CNT_DW       = 32
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               s_axis_in_tvalid,
  input  logic [NUM_BRANCHES-1:0]            peak_detected_i,
  input  logic [NUM_BRANCHES*SCORE_DW-1:0]   score_i,
  output logic                               m_axis_out_tvalid,
  input  logic                               m_axis_out_tready,
  output logic [CNT_DW-1:0]                  m_axis_out_tdata,
  output logic [$clog2(NUM_BRANCHES)-1:0]    m_axis_out_tuser,
  output logic [SCORE_DW-1:0]                score_o
`ifdef PEAK_PICKER_DROP_CNT_EN
  ,
  output logic [15:0]                        dropped_cnt_o
`endif
);

  localparam int BR_W   = $clog2(NUM_BRANCHES);
  localparam int HOLD_W = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_DW-1:0]   sample_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_last;
  logic                capture;
  logic                update;
  logic                hold_inc;
  logic                handshake;

  // Scores are unsigned magnitudes, so the comparisons below are unsigned.
  logic                cand_vld_p0;
  logic [BR_W-1:0]     cand_br_p0;
  logic [SCORE_DW-1:0] cand_score_p0;

`ifdef PEAK_PICKER_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // ---- stage p0: per-sample candidate (combinational) ----
  // Ascending scan with a strict compare keeps the lowest branch on ties.
  always_comb begin
    cand_vld_p0   = 1'b0;
    cand_br_p0    = '0;
    cand_score_p0 = '0;
    for (int b = 0; b < NUM_BRANCHES; b++) begin
      if (peak_detected_i[b] &&
          (!cand_vld_p0 || (score_i[b*SCORE_DW +: SCORE_DW] > cand_score_p0))) begin
        cand_vld_p0   = 1'b1;
        cand_br_p0    = BR_W'(b);
        cand_score_p0 = score_i[b*SCORE_DW +: SCORE_DW];
      end
    end
  end

  assign hold_last = (hold_cnt == HOLD_W'(HOLD_LEN - 1));
  assign handshake = (state == ST_OUTPUT) && m_axis_out_tready;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    hold_inc  = 1'b0;
    update    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s_axis_in_tvalid && cand_vld_p0) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (s_axis_in_tvalid) begin
          hold_inc = 1'b1;
          update   = cand_vld_p0 && (cand_score_p0 > score_o);
          if (hold_last) state_nxt = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        // A peak that arrives together with the accept starts the next window.
        if (m_axis_out_tready) begin
          if (s_axis_in_tvalid && cand_vld_p0) begin
            capture   = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // ---- stage p1: registered counters, best candidate and outputs ----
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sample_cnt        <= '0;
      hold_cnt          <= '0;
      m_axis_out_tvalid <= 1'b0;
      m_axis_out_tdata  <= '0;
      m_axis_out_tuser  <= '0;
      score_o           <= '0;
    end else begin
      if (s_axis_in_tvalid) sample_cnt <= sample_cnt + 1'b1;
      m_axis_out_tvalid <= (state_nxt == ST_OUTPUT);
      if (capture) begin
        hold_cnt <= '0;
      end else if (hold_inc) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      // The best registers drive the outputs directly; they only change
      // outside OUTPUT or on the accept cycle, so the result stays stable.
      if (capture || update) begin
        m_axis_out_tdata <= sample_cnt;
        m_axis_out_tuser <= cand_br_p0;
        score_o          <= cand_score_p0;
      end
    end
  end

`ifdef PEAK_PICKER_DROP_CNT_EN
  logic drop;
  assign drop = (state == ST_OUTPUT) && !handshake && s_axis_in_tvalid && cand_vld_p0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   dropped_cnt_o <= 16'd0;
    else if (drop) dropped_cnt_o <= sat_inc16(dropped_cnt_o);
  end
`endif

endmodule

// File: tb/tb_peak_picker.sv
// Bench for peak_picker: a 32-bit index instance and a 4-bit index
// instance share all stimulus, so the index wrap can be observed
// side by side with the full-width result.
module tb_peak_picker;
  localparam int NB = 3;
  localparam int HL = 4;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_PRESENT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_in;
  logic [2:0]  pk_in;
  logic [47:0] sc_in;
  logic        rdy_in;

  logic        vld_a, vld_b;
  logic [31:0] tdata_a;
  logic [3:0]  tdata_b;
  logic [1:0]  tuser_a, tuser_b;
  logic [15:0] score_a, score_b;
`ifdef PEAK_PICKER_DROP_CNT_EN
  logic [15:0] drop_a, drop_b;
`endif

  always #5 clk = ~clk;

  peak_picker #(.SCORE_DW(16), .NUM_BRANCHES(NB), .HOLD_LEN(HL), .CNT_DW(32)) dut (
    .clk_i(clk), .reset_i(rst), .s_axis_in_tvalid(v_in),
    .peak_detected_i(pk_in), .score_i(sc_in),
    .m_axis_out_tvalid(vld_a), .m_axis_out_tready(rdy_in),
    .m_axis_out_tdata(tdata_a), .m_axis_out_tuser(tuser_a), .score_o(score_a)
`ifdef PEAK_PICKER_DROP_CNT_EN
    , .dropped_cnt_o(drop_a)
`endif
  );

  peak_picker #(.SCORE_DW(16), .NUM_BRANCHES(NB), .HOLD_LEN(HL), .CNT_DW(4)) dut4 (
    .clk_i(clk), .reset_i(rst), .s_axis_in_tvalid(v_in),
    .peak_detected_i(pk_in), .score_i(sc_in),
    .m_axis_out_tvalid(vld_b), .m_axis_out_tready(rdy_in),
    .m_axis_out_tdata(tdata_b), .m_axis_out_tuser(tuser_b), .score_o(score_b)
`ifdef PEAK_PICKER_DROP_CNT_EN
    , .dropped_cnt_o(drop_b)
`endif
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned idx;
    logic [2:0]  pk;
    logic [47:0] sc;
  } sample_t;

  sample_t     win[$];
  int          m_mode;
  int unsigned m_cnt;
  int          m_left;
  logic [31:0] e_tdata;
  logic [1:0]  e_tuser;
  logic [15:0] e_score;
  logic [15:0] m_drop;

  function automatic logic [47:0] sc3(input int s0, input int s1, input int s2);
    return {16'(s2), 16'(s1), 16'(s0)};
  endfunction

  task automatic model_reset();
    win.delete();
    m_mode  = M_IDLE;
    m_cnt   = 0;
    m_left  = 0;
    e_tdata = '0;
    e_tuser = '0;
    e_score = '0;
    m_drop  = '0;
  endtask

  // Winner of a window: the highest score over all samples; among equal
  // scores the earliest sample, then the lowest branch.
  task automatic resolve();
    int mx;
    bit found;
    mx = -1;
    found = 1'b0;
    foreach (win[i])
      for (int b = 0; b < NB; b++)
        if (win[i].pk[b] && int'(win[i].sc[b*16 +: 16]) > mx) mx = int'(win[i].sc[b*16 +: 16]);
    foreach (win[i])
      for (int b = 0; b < NB; b++)
        if (!found && win[i].pk[b] && int'(win[i].sc[b*16 +: 16]) == mx) begin
          found   = 1'b1;
          e_tdata = win[i].idx;
          e_tuser = 2'(b);
          e_score = 16'(mx);
        end
  endtask

  task automatic start_window(input int unsigned idx);
    win.delete();
    win.push_back('{idx, pk_in, sc_in});
    m_left = HL;
    m_mode = M_COLLECT;
  endtask

  task automatic model_edge();
    int unsigned idx;
    bit pk_any;
    idx    = m_cnt;
    pk_any = v_in && (pk_in != 3'b000);
    case (m_mode)
      M_IDLE: if (pk_any) start_window(idx);
      M_COLLECT: begin
        if (v_in) begin
          win.push_back('{idx, pk_in, sc_in});
          m_left--;
          if (m_left == 0) begin
            resolve();
            m_mode = M_PRESENT;
          end
        end
      end
      default: begin
        if (rdy_in) begin
          m_mode = M_IDLE;
          if (pk_any) start_window(idx);
        end else if (pk_any && m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
      end
    endcase
    if (v_in) m_cnt = m_cnt + 1;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit pres;
    pres = (m_mode == M_PRESENT);
    chk("tvalid", 64'(vld_a), 64'(pres));
    chk("tvalid_w4", 64'(vld_b), 64'(pres));
    if (pres) begin
      chk("tdata", 64'(tdata_a), 64'(e_tdata));
      chk("tuser", 64'(tuser_a), 64'(e_tuser));
      chk("score", 64'(score_a), 64'(e_score));
      chk("tdata_w4", 64'(tdata_b), 64'(e_tdata[3:0]));
      chk("tuser_w4", 64'(tuser_b), 64'(e_tuser));
      chk("score_w4", 64'(score_b), 64'(e_score));
    end
`ifdef PEAK_PICKER_DROP_CNT_EN
    chk("dropped", 64'(drop_a), 64'(m_drop));
    chk("dropped_w4", 64'(drop_b), 64'(m_drop));
`endif
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic step(input logic v, input logic [2:0] pk, input logic [47:0] sc, input logic r);
    v_in   = v;
    pk_in  = pk;
    sc_in  = sc;
    rdy_in = r;
    @(posedge clk);
    #1;
    model_edge();
    check_outputs();
  endtask

  task automatic quiet(input logic r);
    step(1'b1, 3'b000, 48'd0, r);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(vld_a), 64'd0);
    chk({tag, "_tdata"},  64'(tdata_a), 64'd0);
    chk({tag, "_tuser"},  64'(tuser_a), 64'd0);
    chk({tag, "_score"},  64'(score_a), 64'd0);
    chk({tag, "_tvalid_w4"}, 64'(vld_b), 64'd0);
    chk({tag, "_tdata_w4"},  64'(tdata_b), 64'd0);
`ifdef PEAK_PICKER_DROP_CNT_EN
    chk({tag, "_dropped"}, 64'(drop_a), 64'd0);
`endif
  endtask

  // Called just after an edge; checks the asynchronous clear before the
  // next edge, then releases reset after one edge.
  task automatic do_reset();
    rst  = 1'b1;
    v_in = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- candidate-selection table ----------------
  typedef struct {
    logic [2:0]  pk;
    int          s0, s1, s2;
    logic [1:0]  tuser;
    logic [15:0] score;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int unsigned pidx;

    vecs[0] = '{3'b010, 0,     100, 0,     2'd1, 16'd100};
    vecs[1] = '{3'b011, 70,    70,  0,     2'd0, 16'd70};
    vecs[2] = '{3'b110, 0,     30,  90,    2'd2, 16'd90};
    vecs[3] = '{3'b111, 5,     9,   9,     2'd1, 16'd9};
    vecs[4] = '{3'b101, 65535, 0,   65535, 2'd0, 16'd65535};
    vecs[5] = '{3'b001, 1,     500, 600,   2'd0, 16'd1};
    vecs[6] = '{3'b100, 7,     7,   0,     2'd2, 16'd0};

    rst = 1'b1; v_in = 1'b0; pk_in = '0; sc_in = '0; rdy_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Single-peak windows; the first peak lands on sample 10.
    repeat (10) quiet(1'b1);
    for (int i = 0; i < 7; i++) begin
      pidx = m_cnt;
      step(1'b1, vecs[i].pk, sc3(vecs[i].s0, vecs[i].s1, vecs[i].s2), 1'b1);
      repeat (3) quiet(1'b1);
      chk("tbl_early", 64'(vld_a), 64'd0);
      quiet(1'b1);
      chk("tbl_tvalid", 64'(vld_a), 64'd1);
      chk("tbl_tdata", 64'(tdata_a), 64'(pidx));
      chk("tbl_tuser", 64'(tuser_a), 64'(vecs[i].tuser));
      chk("tbl_score", 64'(score_a), 64'(vecs[i].score));
      chk("tbl_tdata_w4", 64'(tdata_b), 64'(pidx % 16));
      quiet(1'b1);
      chk("tbl_tvalid_drop", 64'(vld_a), 64'd0);
    end

    // Later strictly-greater peak wins; an equal one later does not.
    do_reset();
    repeat (20) quiet(1'b1);
    step(1'b1, 3'b001, sc3(50, 0, 0), 1'b1);
    quiet(1'b1);
    step(1'b1, 3'b100, sc3(0, 0, 80), 1'b1);
    step(1'b1, 3'b010, sc3(0, 80, 0), 1'b1);
    quiet(1'b1);
    chk("upd_tvalid", 64'(vld_a), 64'd1);
    chk("upd_tdata", 64'(tdata_a), 64'd22);
    chk("upd_tuser", 64'(tuser_a), 64'd2);
    chk("upd_score", 64'(score_a), 64'd80);
    quiet(1'b1);

    // Backpressure: held result, dropped peaks, capture on accept cycle.
    do_reset();
    repeat (25) quiet(1'b1);
    step(1'b1, 3'b001, sc3(10, 0, 0), 1'b0);
    repeat (4) quiet(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 1 || i == 4 || i == 7) step(1'b1, 3'b111, sc3(999, 999, 999), 1'b0);
      else quiet(1'b0);
    end
    chk("bp_tvalid", 64'(vld_a), 64'd1);
    chk("bp_tdata", 64'(tdata_a), 64'd25);
    chk("bp_tuser", 64'(tuser_a), 64'd0);
    chk("bp_score", 64'(score_a), 64'd10);
`ifdef PEAK_PICKER_DROP_CNT_EN
    chk("bp_dropped", 64'(drop_a), 64'd3);
`endif
    step(1'b1, 3'b010, sc3(0, 7, 0), 1'b1);
    chk("hs_tvalid", 64'(vld_a), 64'd0);
    repeat (4) quiet(1'b1);
    chk("hs_tdata", 64'(tdata_a), 64'd40);
    chk("hs_tuser", 64'(tuser_a), 64'd1);
    chk("hs_score", 64'(score_a), 64'd7);
    quiet(1'b1);

    // Reset during a collection window, then during a held result.
    do_reset();
    step(1'b1, 3'b100, sc3(0, 0, 55), 1'b1);
    repeat (2) quiet(1'b1);
    do_reset();
    repeat (6) quiet(1'b1);
    step(1'b1, 3'b010, sc3(0, 3, 0), 1'b1);
    repeat (4) quiet(1'b1);
    chk("rst_tdata", 64'(tdata_a), 64'd6);
    chk("rst_tvalid", 64'(vld_a), 64'd1);
    quiet(1'b0);
    do_reset();
    repeat (8) quiet(1'b1);

    // Index wrap on the 4-bit instance plus gaps in the sample strobe.
    do_reset();
    repeat (17) quiet(1'b1);
    step(1'b1, 3'b001, sc3(4, 0, 0), 1'b1);
    for (int k = 0; k < 4; k++) begin
      repeat (3) step(1'b0, 3'b111, sc3(9, 9, 9), 1'b1);
      quiet(1'b1);
      if (k < 3) chk("gap_early", 64'(vld_a), 64'd0);
    end
    chk("gap_tvalid", 64'(vld_a), 64'd1);
    chk("wrap_tdata_w4", 64'(tdata_b), 64'd1);
    chk("wrap_tdata", 64'(tdata_a), 64'd17);
    quiet(1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic rv, rr;
      logic [2:0] rp;
      logic [47:0] rs;
      if ($urandom_range(0, 399) == 0) do_reset();
      rv = ($urandom_range(0, 3) != 0);
      rp = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      rr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rs = {16'($urandom), 16'($urandom), 16'($urandom)};
      else rs = sc3($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      step(rv, rp, rs, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
